e_mdu: RTL and testbench

E_MDU -- requirements
Module: e_mdu

---
 rtl/e_mdu.sv | 161 ++++++++++++++++
 tb/tb_e_mdu.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit holding HI/LO for the E stage.
// Optional build macro MDU_MADD_EN enables op 110 (signed multiply-accumulate into {HI,LO}).
module e_mdu (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] E_rsValue1,
    input  logic [31:0] E_rtValue1,
    input  logic        E_MDUStart,
    input  logic [2:0]  E_MDUOp,
    output logic        E_MDUBusy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OpMadd  = 3'b110;
`endif

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, b_q;
    logic [2:0]  op_q;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        accept, is_mul, is_div, done;
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_abs, b_abs, sq, sr;
    logic [31:0] res_hi, res_lo;
    logic        res_we;

    assign accept = E_MDUStart && (state_q == StIdle);

    always_comb begin
        is_mul = (E_MDUOp == OpMult) || (E_MDUOp == OpMultu);
        is_div = (E_MDUOp == OpDiv) || (E_MDUOp == OpDivu);
`ifdef MDU_MADD_EN
        if (E_MDUOp == OpMadd) is_mul = 1'b1;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 3'b111;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (accept) begin
                a_q  <= E_rsValue1;
                b_q  <= E_rtValue1;
                op_q <= E_MDUOp;
            end
        end
    end

    // Next-state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept && (is_mul || is_div)) begin
                    state_d = StRun;
                    cnt_d   = is_div ? 4'd10 : 4'd5;
                end
            end
            StRun: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StIdle;
                    done    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Signed divide via magnitudes so INT_MIN / -1 wraps to INT_MIN with no special case
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        a_abs  = a_q[31] ? (32'd0 - a_q) : a_q;
        b_abs  = b_q[31] ? (32'd0 - b_q) : b_q;
        sq     = 32'd0;
        sr     = 32'd0;
        res_hi = hi_q;
        res_lo = lo_q;
        res_we = 1'b0;
        case (op_q)
            OpMult: begin
                {res_hi, res_lo} = prod_s;
                res_we = 1'b1;
            end
            OpMultu: begin
                {res_hi, res_lo} = prod_u;
                res_we = 1'b1;
            end
            OpDiv: begin
                if (b_q != 32'd0) begin
                    sq     = a_abs / b_abs;
                    sr     = a_abs % b_abs;
                    res_lo = (a_q[31] ^ b_q[31]) ? (32'd0 - sq) : sq;
                    res_hi = a_q[31] ? (32'd0 - sr) : sr;
                    res_we = 1'b1;
                end
            end
            OpDivu: begin
                if (b_q != 32'd0) begin
                    res_lo = a_q / b_q;
                    res_hi = a_q % b_q;
                    res_we = 1'b1;
                end
            end
`ifdef MDU_MADD_EN
            OpMadd: begin
                {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
                res_we = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (done && res_we) begin
            hi_d = res_hi;
            lo_d = res_lo;
        end else if (accept && (E_MDUOp == OpMthi)) begin
            hi_d = E_rsValue1;
        end else if (accept && (E_MDUOp == OpMtlo)) begin
            lo_d = E_rsValue1;
        end
    end

    // Outputs
    always_comb begin
        E_MDUBusy = (state_q == StRun);
        HI        = hi_q;
        LO        = lo_q;
    end

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu; inputs driven and outputs sampled on falling edges.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] rs, rt;
    logic        start;
    logic [2:0]  op;
    logic        busy;
    logic [31:0] hi, lo;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    logic [31:0] m_hi, m_lo;

    e_mdu dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .E_rsValue1 (rs),
        .E_rtValue1 (rt),
        .E_MDUStart (start),
        .E_MDUOp    (op),
        .E_MDUBusy  (busy),
        .HI         (hi),
        .LO         (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Returns at the falling edge just after the accepting rising edge
    task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op    = o;
        rs    = a;
        rt    = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rs    = $urandom;
        rt    = $urandom;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        start_op(o, a, b);
        check({tag, " busy@0"}, {31'd0, busy}, 32'd1);
        repeat (lat - 1) @(negedge clk);
        check({tag, " busy@last"}, {31'd0, busy}, 32'd1);
        check({tag, " hi hold"}, hi, m_hi);
        check({tag, " lo hold"}, lo, m_lo);
        @(negedge clk);
        check({tag, " busy fall"}, {31'd0, busy}, 32'd0);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    task automatic move_to(input string tag, input logic [2:0] o, input logic [31:0] v);
        start_op(o, v, 32'hDEAD_BEEF);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        if (o == 3'b100) m_hi = v;
        else m_lo = v;
        check({tag, " hi"}, hi, m_hi);
        check({tag, " lo"}, lo, m_lo);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 3'b111;
        rs      = 32'd0;
        rt      = 32'd0;
        repeat (2) @(negedge clk);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;

        run_op("mult", 3'b000, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("divu", 3'b011, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_op("div", 3'b010, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        move_to("mthi", 3'b100, 32'h11);
        move_to("mtlo", 3'b101, 32'h22);
        run_op("div0", 3'b010, 32'd100, 32'd0, 10, 32'h11, 32'h22);
        run_op("divovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
        run_op("mult neg", 3'b000, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 5, 32'd0, 32'd21);

        // MULTU with an MTLO presented while busy
        start_op(3'b001, 32'hFFFF_FFFF, 32'd2);
        check("multu busy@0", {31'd0, busy}, 32'd1);
        start_op(3'b101, 32'd5, 32'd0);
        repeat (2) @(negedge clk);
        check("multu busy@last", {31'd0, busy}, 32'd1);
        check("multu lo hold", lo, m_lo);
        @(negedge clk);
        check("multu busy fall", {31'd0, busy}, 32'd0);
        check("multu hi", hi, 32'd1);
        check("multu lo", lo, 32'hFFFF_FFFE);
        m_hi = 32'd1;
        m_lo = 32'hFFFF_FFFE;

        start_op(3'b111, 32'h1234, 32'h5678);
        check("nop busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("nop hi", hi, m_hi);
        check("nop lo", lo, m_lo);

        // Reset mid-divide with a start presented during reset
        start_op(3'b010, 32'd50, 32'd7);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        start   = 1'b1;
        op      = 3'b000;
        rs      = 32'd5;
        rt      = 32'd5;
        @(negedge clk);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        start   = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        run_op("post rst", 3'b000, 32'd3, 32'd4, 5, 32'd0, 32'd12);

        move_to("madd mthi", 3'b100, 32'd0);
        move_to("madd mtlo", 3'b101, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
        run_op("madd", 3'b110, 32'd1, 32'd1, 5, 32'd1, 32'd0);
`else
        start_op(3'b110, 32'd1, 32'd1);
        check("madd off busy", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        check("madd off hi", hi, 32'd0);
        check("madd off lo", lo, 32'hFFFF_FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
